// File: rtl/pul_profile_gen_pkg.sv
// Shared widths and FSM segment encodings for the motor pulse profile path.
package pul_profile_gen_pkg;

    // Default widths, shared with the motor controller
    localparam int unsigned PUL_DW = 32;
    localparam int unsigned PUL_CW = 32;
    localparam int unsigned PUL_SW = 16;

    // Segment of the word currently presented on pul_value
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEL  = 2'd1;
    localparam logic [1:0] ST_CRUISE = 2'd2;
    localparam logic [1:0] ST_DECEL  = 2'd3;

endpackage

// File: rtl/pul_profile_gen_sat_step.sv
// Saturating one-step period update: p-delta floored at floor_i, or
// p+delta capped at ceil_i. One extra bit keeps borrow/carry visible.
module pul_sat_step #(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] p_i,
    input  logic [DW-1:0] delta_i,
    input  logic [DW-1:0] floor_i,
    input  logic [DW-1:0] ceil_i,
    input  logic          up_i,
    output logic [DW-1:0] q_o
);

    logic [DW:0] diff;
    logic [DW:0] sum;

    // Select direction and clamp, never wrap
    always_comb begin
        diff = {1'b0, p_i} - {1'b0, delta_i};
        sum  = {1'b0, p_i} + {1'b0, delta_i};
        if (up_i) begin
            q_o = (sum > {1'b0, ceil_i}) ? ceil_i : sum[DW-1:0];
        end else begin
            q_o = (diff[DW] || (diff[DW-1:0] < floor_i)) ? floor_i : diff[DW-1:0];
        end
    end

endmodule

// File: rtl/pul_profile_gen.sv
// Trapezoidal per-pulse period generator: answers each read strobe with the
// next period word (accelerate, cruise, decelerate).
module pul_profile_gen
    import pul_profile_gen_pkg::*;
#(
    parameter int unsigned DW = PUL_DW,
    parameter int unsigned CW = PUL_CW,
    parameter int unsigned SW = PUL_SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] step,
    input  logic [SW-1:0] accel_end,
    input  logic [SW-1:0] decel_begin,
    input  logic [DW-1:0] period_start,
    input  logic [DW-1:0] period_min,
    input  logic [DW-1:0] period_delta,
    input  logic          read,
    output logic [DW-1:0] pul_value,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic          underrun
);

    // Common width for comparing pulse indices against segment bounds
    localparam int unsigned IW = (CW > SW) ? CW : SW;

    logic [CW-1:0] step_q,  step_d;
    logic [SW-1:0] ae_q,    ae_d;
    logic [SW-1:0] db_q,    db_d;
    logic [DW-1:0] pstart_q, pstart_d;
    logic [DW-1:0] pmin_q,  pmin_d;
    logic [DW-1:0] pdelta_q, pdelta_d;
    logic [CW-1:0] idx_q,   idx_d;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] pul_q,   pul_d;
    logic          valid_q, valid_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          err_q,   err_d;
    logic          urun_q,  urun_d;

    logic [CW-1:0] k1;
    logic [1:0]    seg_nxt;
    logic          last;
    logic          cfg_bad;
    logic          accept;
    logic [DW-1:0] stepped;

    function automatic logic [1:0] seg_of(input logic [IW-1:0] k,
                                          input logic [IW-1:0] ae,
                                          input logic [IW-1:0] db);
        if (k < ae)      return ST_ACCEL;
        else if (k < db) return ST_CRUISE;
        else             return ST_DECEL;
    endfunction

    // Index and segment of the word following the one presented
    always_comb begin
        k1      = idx_q + CW'(1);
        last    = (IW'(k1) >= IW'(step_q));
        seg_nxt = seg_of(IW'(k1), IW'(ae_q), IW'(db_q));
        cfg_bad = (step == '0) || (IW'(accel_end) > IW'(decel_begin)) ||
                  (IW'(decel_begin) > IW'(step)) || (period_min == '0) ||
                  (period_min > period_start);
        accept  = !abort && start && !busy_q && !cfg_bad;
    end

    pul_sat_step #(.DW(DW)) u_sat (
        .p_i     (pul_q),
        .delta_i (pdelta_q),
        .floor_i (pmin_q),
        .ceil_i  (pstart_q),
        .up_i    (seg_nxt == ST_DECEL),
        .q_o     (stepped)
    );

    // Next-state: abort first, then handshake while busy, then start when idle
    always_comb begin
        step_d   = step_q;
        ae_d     = ae_q;
        db_d     = db_q;
        pstart_d = pstart_q;
        pmin_d   = pmin_q;
        pdelta_d = pdelta_q;
        idx_d    = idx_q;
        state_d  = state_q;
        pul_d    = pul_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        urun_d   = urun_q;

        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else if (busy_q) begin
            if (read && valid_q) begin
                idx_d = k1;
                if (last) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = seg_nxt;
                    pul_d   = (seg_nxt == ST_CRUISE) ? pul_q : stepped;
                end
            end
        end else if (start) begin
            if (cfg_bad) begin
                err_d = 1'b1;
            end else begin
                step_d   = step;
                ae_d     = accel_end;
                db_d     = decel_begin;
                pstart_d = period_start;
                pmin_d   = period_min;
                pdelta_d = period_delta;
                idx_d    = '0;
                state_d  = seg_of('0, IW'(accel_end), IW'(decel_begin));
                pul_d    = period_start;
                valid_d  = 1'b1;
                busy_d   = 1'b1;
            end
        end

        // Underrun is sticky; an accepted start in the same cycle wins
        if (accept) begin
            urun_d = 1'b0;
        end else if (!abort && read && !valid_q) begin
            urun_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= '0;
            ae_q     <= '0;
            db_q     <= '0;
            pstart_q <= '0;
            pmin_q   <= '0;
            pdelta_q <= '0;
            idx_q    <= '0;
            state_q  <= ST_IDLE;
            pul_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            step_q   <= step_d;
            ae_q     <= ae_d;
            db_q     <= db_d;
            pstart_q <= pstart_d;
            pmin_q   <= pmin_d;
            pdelta_q <= pdelta_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            pul_q    <= pul_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            urun_q   <= urun_d;
        end
    end

    assign pul_value = pul_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;
    assign underrun  = urun_q;

endmodule
